// File: rtl/mul_unit.sv
// -----------------------------------------------------------------------------
// mul_unit
//
// Iterative shift-and-add multiplier for the execute stage of an in-order
// pipeline. A MUL in E is stalled (Mul=1) while the unit walks the multiplier
// one bit per cycle. The walk stops as soon as the remaining multiplier bits
// are all zero. A single-cycle DONE state then presents the low WIDTH bits of
// the product and lets E advance.
//
// Timing: Mul is high for 2+L consecutive cycles, where L is the bit length of
// SrcBE (0 for SrcBE==0). MulDone follows immediately for one cycle.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous, active-low reset
//   MulE       in   a MUL instruction occupies E this cycle
//   SrcAE      in   [WIDTH] multiplicand, sampled only on the IDLE->BUSY edge
//   SrcBE      in   [WIDTH] multiplier, sampled only on the IDLE->BUSY edge
//   Mul        out  stall request to the hazard unit (holds F, D and E)
//   MulResult  out  [WIDTH] low WIDTH bits of SrcAE*SrcBE; equals Acc always
//   MulDone    out  one-cycle strobe: MulResult is valid and E advances
// -----------------------------------------------------------------------------
module mul_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             MulE,
  input  logic [WIDTH-1:0] SrcAE,
  input  logic [WIDTH-1:0] SrcBE,
  output logic             Mul,
  output logic [WIDTH-1:0] MulResult,
  output logic             MulDone
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] areg_q, areg_d;
  logic [WIDTH-1:0] breg_q, breg_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic start;   // IDLE edge that captures a new operand pair
  logic finish;  // BUSY cycle with no multiplier bits left to process

  assign start  = (state_q == IDLE) && MulE;
  // The counter guard is redundant once Breg has shifted out all WIDTH bits,
  // but it bounds the walk even if Breg were somehow never to reach zero.
  assign finish = (breg_q == '0) || (cnt_q == CNT_LAST);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state is written with non-blocking assignments so every flop
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default before the case statement,
  // so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (MulE)   state_d = BUSY;
      BUSY: if (finish) state_d = DONE;
      // MulE seen in DONE still belongs to the instruction that is completing,
      // so DONE always returns to IDLE and never restarts directly.
      DONE:             state_d = IDLE;
      default:          state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // The stall is gated by rst: during reset the state is forced to IDLE, and
    // a MulE still high from the aborted instruction must not raise a stall.
    Mul       = rst && (start || (state_q == BUSY));
    MulDone   = (state_q == DONE);
    MulResult = acc_q;
  end

  // ---------------------------------------------------------------------------
  // Datapath next-value logic
  // ---------------------------------------------------------------------------
  always_comb begin
    areg_d = areg_q;
    breg_d = breg_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    if (start) begin
      areg_d = SrcAE;
      breg_d = SrcBE;
      acc_d  = '0;
      cnt_d  = '0;
    end else if ((state_q == BUSY) && !finish) begin
      // One multiplier bit per cycle: add the aligned multiplicand when the
      // current LSB is set. The sum wraps, which keeps exactly the low WIDTH
      // product bits (identical for signed and unsigned operands).
      acc_d  = acc_q + (breg_q[0] ? areg_q : '0);
      areg_d = areg_q << 1;
      breg_d = breg_q >> 1;
      cnt_d  = cnt_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  // Acc stays loaded after DONE, so MulResult holds the last product until the
  // next operation starts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      areg_q <= '0;
      breg_q <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
    end else begin
      areg_q <= areg_d;
      breg_q <= breg_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mul_unit.sv
// -----------------------------------------------------------------------------
// tb_mul_unit
//
// Self-checking bench for mul_unit (WIDTH=32). Directed vectors come from a
// table of {operands, product, stall length}; hand-written sequences cover
// back-to-back operations and reset during an operation. A randomized
// regression compares each result with (A*B) mod 2^32 and each stall length
// with 2 + bitlen(B), both computed with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_mul_unit;

  localparam int WIDTH   = 32;
  localparam int N_RAND  = 1500;
  localparam int MAX_CYC = 60;

  logic             clk;
  logic             rst;
  logic             MulE;
  logic [WIDTH-1:0] SrcAE;
  logic [WIDTH-1:0] SrcBE;
  logic             Mul;
  logic [WIDTH-1:0] MulResult;
  logic             MulDone;

  int n_checks = 0;
  int n_errors = 0;

  mul_unit #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .MulE      (MulE),
    .SrcAE     (SrcAE),
    .SrcBE     (SrcBE),
    .Mul       (Mul),
    .MulResult (MulResult),
    .MulDone   (MulDone)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          stall;
    bit          scramble;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", name, act, exp);
    end
  endtask

  function automatic int bitlen(input logic [31:0] v);
    int n = 0;
    logic [31:0] t = v;
    while (t != 0) begin
      n++;
      t = t >> 1;
    end
    return n;
  endfunction

  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    return p[31:0];
  endfunction

  // Runs one MUL starting from IDLE: MulE is held (or randomly toggled and the
  // operands scrambled when scramble=1) until MulDone, then dropped for one
  // IDLE cycle in which the result must hold and no new stall may appear.
  task automatic do_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input int exp_stall, input bit scramble);
    int          stall;
    int          cyc;
    bit          done_seen;
    logic [31:0] res;
    stall     = 0;
    cyc       = 0;
    done_seen = 1'b0;
    res       = '0;
    @(posedge clk); #1;
    MulE  = 1'b1;
    SrcAE = a;
    SrcBE = b;
    while (!done_seen && cyc < MAX_CYC) begin
      @(negedge clk);
      if (MulDone) begin
        done_seen = 1'b1;
        res       = MulResult;
        check($sformatf("%s mul_in_done", tag), 64'(Mul), 64'd0);
      end else begin
        if (Mul) stall++;
        @(posedge clk); #1;
        cyc++;
        if (scramble) begin
          SrcAE = $urandom;
          SrcBE = $urandom;
          MulE  = 1'($urandom_range(0, 1));
        end
      end
    end
    check($sformatf("%s done_seen", tag), 64'(done_seen), 64'd1);
    check($sformatf("%s result", tag), 64'(res), 64'(exp_res));
    check($sformatf("%s stall_cycles", tag), 64'(stall), 64'(exp_stall));
    check($sformatf("%s done_latency", tag), 64'(cyc), 64'(exp_stall));
    @(posedge clk); #1;
    MulE  = 1'b0;
    SrcAE = $urandom;
    SrcBE = $urandom;
    @(negedge clk);
    check($sformatf("%s idle_mul", tag), 64'(Mul), 64'd0);
    check($sformatf("%s idle_done", tag), 64'(MulDone), 64'd0);
    check($sformatf("%s idle_hold", tag), 64'(MulResult), 64'(exp_res));
  endtask

  initial begin
    int          done_cyc[$];
    logic [31:0] done_res[$];
    int          mul_high;
    int          rst_dones;
    int          rst_muls;
    logic [31:0] ra;
    logic [31:0] rb;

    vecs[0] = '{32'd7,          32'd6,          32'd42,         5,  1'b0};
    vecs[1] = '{32'h1234_5678,  32'd0,          32'd0,          2,  1'b0};
    vecs[2] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001,  34, 1'b0};
    vecs[3] = '{32'd3,          32'd5,          32'd15,         5,  1'b1};
    vecs[4] = '{32'h0001_0000,  32'h0001_0000,  32'd0,          19, 1'b1};
    vecs[5] = '{32'd1,          32'd1,          32'd1,          3,  1'b0};
    vecs[6] = '{32'h8000_0000,  32'd2,          32'd0,          4,  1'b0};
    vecs[7] = '{32'hFFFF_FFFF,  32'h8000_0000,  32'h8000_0000,  34, 1'b1};
    vecs[8] = '{32'd5,          32'hFFFF_FFFF,  32'hFFFF_FFFB,  34, 1'b0};

    // Reset state, with MulE high to show it cannot raise a stall in reset.
    rst   = 1'b0;
    MulE  = 1'b1;
    SrcAE = 32'd7;
    SrcBE = 32'd6;
    repeat (3) @(negedge clk);
    check("reset mul", 64'(Mul), 64'd0);
    check("reset done", 64'(MulDone), 64'd0);
    check("reset result", 64'(MulResult), 64'd0);
    MulE = 1'b0;
    rst  = 1'b1;
    @(negedge clk);
    check("post_reset idle_mul", 64'(Mul), 64'd0);

    // Directed table.
    for (int i = 0; i < 9; i++) begin
      do_mul($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].res,
             vecs[i].stall, vecs[i].scramble);
    end

    // Back-to-back with MulE held: 3*5 (done at cycle 5), IDLE start at cycle
    // 6, then 0x10000*0x10000 (19 stall cycles, done at cycle 25). Operands
    // are random in every cycle except the two sampling cycles.
    mul_high = 0;
    @(posedge clk); #1;
    for (int c = 0; c < 30; c++) begin
      MulE = (c <= 25);
      if (c == 0) begin
        SrcAE = 32'd3;
        SrcBE = 32'd5;
      end else if (c == 6) begin
        SrcAE = 32'h0001_0000;
        SrcBE = 32'h0001_0000;
      end else begin
        SrcAE = $urandom;
        SrcBE = $urandom;
      end
      @(negedge clk);
      if (Mul) mul_high++;
      if (MulDone) begin
        done_cyc.push_back(c);
        done_res.push_back(MulResult);
      end
      @(posedge clk); #1;
    end
    check("b2b done_count", 64'(done_cyc.size()), 64'd2);
    if (done_cyc.size() >= 2) begin
      check("b2b done0_cycle", 64'(done_cyc[0]), 64'd5);
      check("b2b done0_result", 64'(done_res[0]), 64'd15);
      check("b2b done1_cycle", 64'(done_cyc[1]), 64'd25);
      check("b2b done1_result", 64'(done_res[1]), 64'd0);
    end
    check("b2b mul_cycles", 64'(mul_high), 64'd24);
    MulE = 1'b0;

    // Reset 10 cycles into a long multiply; MulE stays high through reset.
    @(posedge clk); #1;
    MulE  = 1'b1;
    SrcAE = 32'hFFFF_FFFF;
    SrcBE = 32'hFFFF_FFFF;
    repeat (10) @(posedge clk);
    #1;
    check("abort pre_mul", 64'(Mul), 64'd1);
    rst = 1'b0;
    #1;
    check("abort mul", 64'(Mul), 64'd0);
    check("abort result", 64'(MulResult), 64'd0);
    check("abort done", 64'(MulDone), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    MulE = 1'b0;
    rst  = 1'b1;
    rst_dones = 0;
    rst_muls  = 0;
    repeat (40) begin
      @(negedge clk);
      if (MulDone) rst_dones++;
      if (Mul) rst_muls++;
    end
    check("abort no_done", 64'(rst_dones), 64'd0);
    check("abort no_stall", 64'(rst_muls), 64'd0);
    do_mul("post_abort", 32'd2, 32'd3, 32'd6, 4, 1'b0);

    // Randomized regression; multiplier lengths spread by a random shift.
    for (int i = 0; i < N_RAND; i++) begin
      ra = $urandom;
      rb = $urandom;
      rb = rb >> $urandom_range(0, 32);
      do_mul($sformatf("rand%0d", i), ra, rb, ref_mul(ra, rb), 2 + bitlen(rb),
             1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
